toe_host_ctrl: RTL

TOE_HOST_CTRL -- requirements
Module: toe_host_ctrl

---
 rtl/toe_host_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/toe_host_ctrl.sv
// TOE host controller: turns open/kill requests into command-register writes,
// polls the init engine's status register and returns one response per request.
module toe_host_ctrl #(
  parameter int POLL_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [3:0]  req_kill_id,
  input  logic [33:0] req_tuple,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [3:0]  rsp_id,
  output logic [1:0]  rsp_status,
  output logic        chipselect,
  output logic        write,
  output logic        read,
  output logic        address,
  output logic [63:0] writedata,
  input  logic [31:0] readdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_CMD  = 3'd1,
    WR_CLR  = 3'd2,
    RD_STAT = 3'd3,
    WAIT_RD = 3'd4,
    RESP    = 3'd5
  } state_t;

  localparam logic [7:0] POLL_LAST = 8'(POLL_LIMIT - 1);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ERROR   = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  poll_cnt;
  logic [7:0]  poll_cnt_nxt;
  logic        op_q;
  logic [3:0]  kill_id_q;
  logic        accept;

  logic        req_ready_nxt;
  logic        rsp_valid_nxt;
  logic [3:0]  rsp_id_nxt;
  logic [1:0]  rsp_status_nxt;
  logic        chipselect_nxt;
  logic        write_nxt;
  logic        read_nxt;
  logic        address_nxt;
  logic [63:0] writedata_nxt;

  // Status register fields; upper bits carry nothing for us
  logic [3:0]  stat_new_id;
  logic [1:0]  stat_done;
  logic [1:0]  stat_error;
  logic        unused_readdata;

  assign stat_new_id     = readdata[3:0];
  assign stat_done       = readdata[5:4];
  assign stat_error      = readdata[7:6];
  assign unused_readdata = ^readdata[31:8];

  assign accept = (state == IDLE) && req_valid;

  // Command word: new_request in [1:0], kill_request in [3:2], kill_id in [7:4],
  // tuple in [41:8]. The kill_id field is zeroed for opens.
  function automatic logic [63:0] cmd_word(input logic op, input logic [3:0] kid,
                                           input logic [33:0] tup);
    logic [1:0] new_req;
    logic [1:0] kill_req;
    logic [3:0] kid_f;
    new_req  = op ? 2'b00 : 2'b01;
    kill_req = op ? 2'b01 : 2'b00;
    kid_f    = op ? kid : 4'd0;
    return {22'd0, tup, kid_f, kill_req, new_req};
  endfunction

  // Request fields are loaded only on accept, so they need no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q      <= req_op;
      kill_id_q <= req_kill_id;
    end
  end

  // Next-state decode plus next value of every registered output
  always_comb begin
    state_nxt      = state;
    poll_cnt_nxt   = poll_cnt;
    rsp_id_nxt     = rsp_id;
    rsp_status_nxt = rsp_status;

    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt    = WR_CMD;
          poll_cnt_nxt = 8'd0;
        end
      end
      WR_CMD:  state_nxt = WR_CLR;
      WR_CLR:  state_nxt = RD_STAT;
      RD_STAT: state_nxt = WAIT_RD;
      WAIT_RD: begin
        // Error wins over done when both are reported together
        if (stat_error != 2'b00) begin
          state_nxt      = RESP;
          rsp_status_nxt = ST_ERROR;
          rsp_id_nxt     = op_q ? kill_id_q : 4'd0;
        end else if (stat_done != 2'b00) begin
          state_nxt      = RESP;
          rsp_status_nxt = ST_OK;
          rsp_id_nxt     = op_q ? kill_id_q : stat_new_id;
        end else if (poll_cnt == POLL_LAST) begin
          state_nxt      = RESP;
          rsp_status_nxt = ST_TIMEOUT;
          rsp_id_nxt     = op_q ? kill_id_q : 4'd0;
        end else begin
          state_nxt    = RD_STAT;
          poll_cnt_nxt = poll_cnt + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt      = IDLE;
          rsp_id_nxt     = 4'd0;
          rsp_status_nxt = ST_OK;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered
    req_ready_nxt  = (state_nxt == IDLE);
    rsp_valid_nxt  = (state_nxt == RESP);
    write_nxt      = (state_nxt == WR_CMD) || (state_nxt == WR_CLR);
    read_nxt       = (state_nxt == RD_STAT);
    chipselect_nxt = write_nxt || read_nxt;
    address_nxt    = read_nxt;
    writedata_nxt  = 64'd0;
    if (state_nxt == WR_CMD) begin
      writedata_nxt = cmd_word(req_op, req_kill_id, req_tuple);
    end
  end

  // State, poll counter and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      poll_cnt   <= 8'd0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_id     <= 4'd0;
      rsp_status <= ST_OK;
      chipselect <= 1'b0;
      write      <= 1'b0;
      read       <= 1'b0;
      address    <= 1'b0;
      writedata  <= 64'd0;
    end else begin
      state      <= state_nxt;
      poll_cnt   <= poll_cnt_nxt;
      req_ready  <= req_ready_nxt;
      rsp_valid  <= rsp_valid_nxt;
      rsp_id     <= rsp_id_nxt;
      rsp_status <= rsp_status_nxt;
      chipselect <= chipselect_nxt;
      write      <= write_nxt;
      read       <= read_nxt;
      address    <= address_nxt;
      writedata  <= writedata_nxt;
    end
  end

endmodule
